// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_pkg
// Purpose  : Shared widths, index helper, link payload type and host FSM
//            state encoding for the replicated data memory.
// Revision : 1.0 - initial release
// ============================================================================
package memory_pkg;

    localparam int unsigned TIA_WORD_WIDTH            = 32;
    localparam int unsigned TIA_MMIO_INDEX_WIDTH      = 32;
    localparam int unsigned TIA_MMIO_DATA_WIDTH       = 32;
    localparam int unsigned TIA_NUM_DATA_MEMORY_WORDS = 256;

    // Host MMIO indices address whole words, so the word index starts at bit 0.
    localparam int unsigned MMIO_WORD_SHIFT = 0;

    typedef logic [TIA_WORD_WIDTH-1:0] link_word_t;

    typedef enum logic [0:0] {
        HOST_IDLE = 1'b0,
        HOST_ACK  = 1'b1
    } host_state_t;

    // Bits needed to address a bank; never less than one.
    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_1r_1w.sv
`default_nettype none
// ============================================================================
// Module   : ram_1r_1w
// Purpose  : One storage bank: synchronous registered read, one write port,
//            optional same-cycle write forwarding and an optional host tap
//            read port used only by the bank that serves host MMIO reads.
// Revision : 1.0 - initial release
// ============================================================================
module ram_1r_1w #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned INDEX_WIDTH  = 8,
    parameter int unsigned WIDTH        = 32,
    parameter bit          WRITE_BYPASS = 1'b0,
    parameter bit          HOST_TAP     = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   read_enable,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [WIDTH-1:0]       read_data,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [WIDTH-1:0]       write_data,
    input  logic                   tap_enable,
    input  logic [INDEX_WIDTH-1:0] tap_index,
    output logic [WIDTH-1:0]       tap_data
);

    logic [WIDTH-1:0] ram [DEPTH];
    logic             w_forward;

    generate
        if (WRITE_BYPASS) begin : g_bypass
            assign w_forward = write_enable && (write_index == read_index);
        end else begin : g_no_bypass
            assign w_forward = 1'b0;
        end
    endgenerate

    // Storage array; contents survive reset.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            ram[write_index] <= write_data;
        end
    end

    // Read register doubles as the port's held output data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data <= '0;
        end else if (read_enable) begin
            read_data <= w_forward ? write_data : ram[read_index];
        end
    end

    generate
        if (HOST_TAP) begin : g_host_tap
            // Host read register, loaded once per host read request.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    tap_data <= '0;
                end else if (tap_enable) begin
                    tap_data <= ram[tap_index];
                end
            end
        end else begin : g_no_tap
            logic w_tap_unused;
            assign w_tap_unused = ^{tap_enable, tap_index};
            assign tap_data     = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/memory_nr_1w.sv
`default_nettype none
// ============================================================================
// Module   : memory_nr_1w
// Purpose  : Parametrised data memory with NUM_READ_PORTS link read channels,
//            one joined link write channel and a host MMIO path. One bank per
//            read port; every write is broadcast to all banks.
// Revision : 1.0 - initial release
// ============================================================================
module memory_nr_1w
    import memory_pkg::*;
#(
    parameter int unsigned NUM_READ_PORTS = 4,
    parameter int unsigned DEPTH          = TIA_NUM_DATA_MEMORY_WORDS,
    parameter bit          WRITE_BYPASS   = 1'b0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          enable,
    // host MMIO
    input  logic                                          host_read_req,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0]               host_read_index,
    output logic                                          host_read_ack,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]                host_read_data,
    input  logic                                          host_write_req,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0]               host_write_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]                host_write_data,
    output logic                                          host_write_ack,
    // read index links (receivers)
    input  logic [NUM_READ_PORTS-1:0]                     read_index_input_links_req,
    input  logic [NUM_READ_PORTS-1:0][TIA_WORD_WIDTH-1:0] read_index_input_links_data,
    output logic [NUM_READ_PORTS-1:0]                     read_index_input_links_ack,
    // read data links (senders)
    output logic [NUM_READ_PORTS-1:0]                     read_data_output_links_req,
    output logic [NUM_READ_PORTS-1:0][TIA_WORD_WIDTH-1:0] read_data_output_links_data,
    input  logic [NUM_READ_PORTS-1:0]                     read_data_output_links_ack,
    // write links (receivers)
    input  logic                                          write_index_input_link_req,
    input  logic [TIA_WORD_WIDTH-1:0]                     write_index_input_link_data,
    output logic                                          write_index_input_link_ack,
    input  logic                                          write_data_input_link_req,
    input  logic [TIA_WORD_WIDTH-1:0]                     write_data_input_link_data,
    output logic                                          write_data_input_link_ack,
    output logic                                          quiescent
);

    localparam int unsigned c_INDEX_WIDTH = index_width(DEPTH);

    logic                                          r_active;
    logic [NUM_READ_PORTS-1:0]                     r_valid;
    logic [NUM_READ_PORTS-1:0]                     w_index_ack;
    logic [NUM_READ_PORTS-1:0]                     w_accept;
    logic [NUM_READ_PORTS-1:0][TIA_WORD_WIDTH-1:0] w_tap_data;

    logic                     w_link_write;
    logic                     w_host_write_fire;
    logic                     w_host_read_fire;
    logic                     w_bank_we;
    logic [c_INDEX_WIDTH-1:0] w_bank_windex;
    link_word_t               w_bank_wdata;
    logic [c_INDEX_WIDTH-1:0] w_host_rindex;
    logic [c_INDEX_WIDTH-1:0] w_host_windex;

    host_state_t r_wr_state, w_wr_state_next;
    host_state_t r_rd_state, w_rd_state_next;

    logic w_lint_unused;
    assign w_lint_unused = ^{read_index_input_links_data, write_index_input_link_data,
                             host_read_index, host_write_index, w_tap_data};

    // Holds link handshakes off until the first edge after reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Write join: both write links must present before either is acked.
    assign w_link_write = r_active && enable &&
                          write_index_input_link_req && write_data_input_link_req;
    assign write_index_input_link_ack = w_link_write;
    assign write_data_input_link_ack  = w_link_write;

    assign w_host_windex = host_write_index[MMIO_WORD_SHIFT +: c_INDEX_WIDTH];
    assign w_host_rindex = host_read_index[MMIO_WORD_SHIFT +: c_INDEX_WIDTH];

    // Link writes take priority over a host write in the same cycle.
    assign w_bank_we     = w_link_write || w_host_write_fire;
    assign w_bank_windex = w_link_write ? write_index_input_link_data[c_INDEX_WIDTH-1:0]
                                        : w_host_windex;
    assign w_bank_wdata  = w_link_write ? write_data_input_link_data
                                        : link_word_t'(host_write_data);

    genvar p;
    generate
        for (p = 0; p < NUM_READ_PORTS; p++) begin : g_bank
            assign w_index_ack[p] = r_active && enable &&
                                    (!r_valid[p] || read_data_output_links_ack[p]);
            assign w_accept[p]    = read_index_input_links_req[p] && w_index_ack[p];

            ram_1r_1w #(
                .DEPTH        (DEPTH),
                .INDEX_WIDTH  (c_INDEX_WIDTH),
                .WIDTH        (TIA_WORD_WIDTH),
                .WRITE_BYPASS (WRITE_BYPASS),
                .HOST_TAP     (p == 0)
            ) u_ram (
                .clock        (clock),
                .reset        (reset),
                .read_enable  (w_accept[p]),
                .read_index   (read_index_input_links_data[p][c_INDEX_WIDTH-1:0]),
                .read_data    (read_data_output_links_data[p]),
                .write_enable (w_bank_we),
                .write_index  (w_bank_windex),
                .write_data   (w_bank_wdata),
                .tap_enable   ((p == 0) ? w_host_read_fire : 1'b0),
                .tap_index    (w_host_rindex),
                .tap_data     (w_tap_data[p])
            );
        end
    endgenerate

    assign read_index_input_links_ack = w_index_ack;
    assign read_data_output_links_req = r_valid;

    // Per-port valid: set on accept, cleared when the consumer takes the data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_READ_PORTS; i++) begin
                if (w_accept[i]) begin
                    r_valid[i] <= 1'b1;
                end else if (read_data_output_links_ack[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Host FSM state registers, one per direction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_state <= HOST_IDLE;
            r_rd_state <= HOST_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
            r_rd_state <= w_rd_state_next;
        end
    end

    // Host write: one RAM write per request, waiting out link writes.
    always_comb begin
        w_wr_state_next   = r_wr_state;
        w_host_write_fire = 1'b0;
        case (r_wr_state)
            HOST_IDLE: begin
                if (host_write_req && !w_link_write) begin
                    w_host_write_fire = 1'b1;
                    w_wr_state_next   = HOST_ACK;
                end
            end
            HOST_ACK: begin
                if (!host_write_req) begin
                    w_wr_state_next = HOST_IDLE;
                end
            end
            default: w_wr_state_next = HOST_IDLE;
        endcase
    end

    // Host read: sample bank 0 once, then hold data and ack while requested.
    always_comb begin
        w_rd_state_next  = r_rd_state;
        w_host_read_fire = 1'b0;
        case (r_rd_state)
            HOST_IDLE: begin
                if (host_read_req) begin
                    w_host_read_fire = 1'b1;
                    w_rd_state_next  = HOST_ACK;
                end
            end
            HOST_ACK: begin
                if (!host_read_req) begin
                    w_rd_state_next = HOST_IDLE;
                end
            end
            default: w_rd_state_next = HOST_IDLE;
        endcase
    end

    assign host_write_ack = (r_wr_state == HOST_ACK);
    assign host_read_ack  = (r_rd_state == HOST_ACK);
    assign host_read_data = TIA_MMIO_DATA_WIDTH'(w_tap_data[0]);

    assign quiescent = !(|r_valid) && !(|read_index_input_links_req) &&
                       !write_index_input_link_req && !write_data_input_link_req &&
                       !host_read_req && !host_write_req &&
                       !host_read_ack && !host_write_ack;

endmodule
`default_nettype wire

// File: tb/tb_memory_nr_1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_nr_1w
// Purpose  : Directed self-checking bench for memory_nr_1w (4 ports, 256
//            words, no write forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_nr_1w;

    localparam int unsigned NP = 4;
    localparam int unsigned W  = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              host_read_req;
    logic [31:0]       host_read_index;
    logic              host_read_ack;
    logic [31:0]       host_read_data;
    logic              host_write_req;
    logic [31:0]       host_write_index;
    logic [31:0]       host_write_data;
    logic              host_write_ack;
    logic [NP-1:0]         ri_req;
    logic [NP-1:0][W-1:0]  ri_data;
    logic [NP-1:0]         ri_ack;
    logic [NP-1:0]         ro_req;
    logic [NP-1:0][W-1:0]  ro_data;
    logic [NP-1:0]         ro_ack;
    logic              wi_req;
    logic [W-1:0]      wi_data;
    logic              wi_ack;
    logic              wd_req;
    logic [W-1:0]      wd_data;
    logic              wd_ack;
    logic              quiescent;

    int checks = 0;
    int errors = 0;

    memory_nr_1w #(
        .NUM_READ_PORTS (NP),
        .DEPTH          (256),
        .WRITE_BYPASS   (1'b0)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .enable                      (enable),
        .host_read_req               (host_read_req),
        .host_read_index             (host_read_index),
        .host_read_ack               (host_read_ack),
        .host_read_data              (host_read_data),
        .host_write_req              (host_write_req),
        .host_write_index            (host_write_index),
        .host_write_data             (host_write_data),
        .host_write_ack              (host_write_ack),
        .read_index_input_links_req  (ri_req),
        .read_index_input_links_data (ri_data),
        .read_index_input_links_ack  (ri_ack),
        .read_data_output_links_req  (ro_req),
        .read_data_output_links_data (ro_data),
        .read_data_output_links_ack  (ro_ack),
        .write_index_input_link_req  (wi_req),
        .write_index_input_link_data (wi_data),
        .write_index_input_link_ack  (wi_ack),
        .write_data_input_link_req   (wd_req),
        .write_data_input_link_data  (wd_data),
        .write_data_input_link_ack   (wd_ack),
        .quiescent                   (quiescent)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        host_read_req = 1'b0; host_read_index = '0;
        host_write_req = 1'b0; host_write_index = '0; host_write_data = '0;
        ri_req = '0; ri_data = '0; ro_ack = '0;
        wi_req = 1'b0; wi_data = '0; wd_req = 1'b0; wd_data = '0;

        for (int i = 0; i < 256; i++) begin
            dut.g_bank[0].u_ram.ram[i] = 32'(i);
            dut.g_bank[1].u_ram.ram[i] = 32'(i);
            dut.g_bank[2].u_ram.ram[i] = 32'(i);
            dut.g_bank[3].u_ram.ram[i] = 32'(i);
        end

        repeat (2) tick();
        // reset state
        check_value("rst_ri_ack",   32'(ri_ack), 32'h0);
        check_value("rst_wr_acks",  32'({wi_ack, wd_ack}), 32'h0);
        check_value("rst_ro_req",   32'(ro_req), 32'h0);
        check_value("rst_ro_data",  ro_data[2], 32'h0);
        check_value("rst_host_ack", 32'({host_read_ack, host_write_ack}), 32'h0);
        check_value("rst_host_rd",  host_read_data, 32'h0);
        check_value("rst_quiet",    32'(quiescent), 32'h1);
        reset = 1'b0;
        repeat (2) tick();

        // single read on port 2
        ri_req[2] = 1'b1; ri_data[2] = 32'd5;
        #1 check_value("p2_ack", 32'(ri_ack[2]), 32'h1);
        tick();
        ri_req[2] = 1'b0;
        check_value("p2_req",  32'(ro_req), 32'h4);
        check_value("p2_data", ro_data[2], 32'd5);
        check_value("p2_busy", 32'(quiescent), 32'h0);
        ro_ack = '1;
        tick();
        check_value("p2_drain", 32'(ro_req), 32'h0);
        check_value("p2_quiet", 32'(quiescent), 32'h1);

        // all ports streaming back to back
        for (int k = 0; k < 4; k++) begin
            ri_req = '1;
            for (int p = 0; p < NP; p++) ri_data[p] = 32'(7 + p + k);
            #1 check_value("stream_ack", 32'(ri_ack), 32'hF);
            tick();
            check_value("stream_req", 32'(ro_req), 32'hF);
            for (int p = 0; p < NP; p++)
                check_value($sformatf("stream_p%0d_k%0d", p, k), ro_data[p], 32'(7 + p + k));
        end
        ri_req = '0;
        tick();
        check_value("stream_done", 32'(ro_req), 32'h0);

        // port 0 consumer stall
        ro_ack = 4'b1110; ri_req = '1;
        for (int p = 0; p < NP; p++) ri_data[p] = 32'(20 + p);
        #1 check_value("stall_first_ack", 32'(ri_ack), 32'hF);
        tick();
        for (int p = 0; p < NP; p++) ri_data[p] = 32'(30 + p);
        for (int s = 0; s < 3; s++) begin
            #1 check_value("stall_ack", 32'(ri_ack), 32'hE);
            tick();
            check_value("stall_req0",  32'(ro_req[0]), 32'h1);
            check_value("stall_hold0", ro_data[0], 32'd20);
            check_value("stall_p1",    ro_data[1], 32'd31);
            check_value("stall_p3",    ro_data[3], 32'd33);
        end
        ro_ack = '1;
        #1 check_value("unstall_ack", 32'(ri_ack), 32'hF);
        tick();
        check_value("unstall_p0", ro_data[0], 32'd30);
        ri_req = '0;
        tick();
        check_value("unstall_done", 32'(ro_req), 32'h0);

        // write 0xBEEF to 12 with same-cycle read of 12
        ri_req = '1; ri_data = {4{32'd12}};
        wi_req = 1'b1; wi_data = 32'd12; wd_req = 1'b1; wd_data = 32'hBEEF;
        #1 check_value("wr12_acks", 32'({wi_ack, wd_ack}), 32'h3);
        tick();
        wi_req = 1'b0; wd_req = 1'b0;
        for (int p = 0; p < NP; p++) check_value("wr12_old", ro_data[p], 32'd12);
        tick();
        for (int p = 0; p < NP; p++) check_value("wr12_new", ro_data[p], 32'hBEEF);
        ri_req = '0;
        tick();

        // write index alone is never acked; data arrives later
        wi_req = 1'b1; wi_data = 32'd40;
        for (int s = 0; s < 4; s++) begin
            #1 check_value("join_wait", 32'({wi_ack, wd_ack}), 32'h0);
            tick();
        end
        wd_req = 1'b1; wd_data = 32'h1234;
        #1 check_value("join_fire", 32'({wi_ack, wd_ack}), 32'h3);
        tick();
        wi_req = 1'b0; wd_req = 1'b0;
        ri_req[1] = 1'b1; ri_data[1] = 32'd40;
        ri_req[2] = 1'b1; ri_data[2] = 32'h105;   // wraps to index 5
        tick();
        ri_req = '0;
        check_value("join_read", ro_data[1], 32'h1234);
        check_value("wrap_read", ro_data[2], 32'd5);
        tick();

        // enable low gates every input ack
        enable = 1'b0; ri_req[1] = 1'b1; wi_req = 1'b1; wd_req = 1'b1;
        #1 check_value("dis_ri_ack", 32'(ri_ack), 32'h0);
        check_value("dis_wr_ack", 32'({wi_ack, wd_ack}), 32'h0);
        tick();
        enable = 1'b1; ri_req = '0; wi_req = 1'b0; wd_req = 1'b0;
        tick();

        // host write concurrent with a link write
        host_write_req = 1'b1; host_write_index = 32'd3; host_write_data = 32'h55;
        wi_req = 1'b1; wi_data = 32'd4; wd_req = 1'b1; wd_data = 32'h66;
        #1 check_value("hw_link_acks", 32'({wi_ack, wd_ack}), 32'h3);
        tick();
        wi_req = 1'b0; wd_req = 1'b0;
        check_value("hw_ack_wait", 32'(host_write_ack), 32'h0);
        tick();
        check_value("hw_ack_rise", 32'(host_write_ack), 32'h1);
        tick();
        check_value("hw_ack_hold", 32'(host_write_ack), 32'h1);
        host_write_req = 1'b0;
        tick();
        check_value("hw_ack_fall", 32'(host_write_ack), 32'h0);

        // host read of 3, link reads of 3 and 4
        host_read_req = 1'b1; host_read_index = 32'd3;
        ri_req[3] = 1'b1; ri_data[3] = 32'd3;
        ri_req[0] = 1'b1; ri_data[0] = 32'd4;
        tick();
        ri_req = '0;
        check_value("hr_ack",   32'(host_read_ack), 32'h1);
        check_value("hr_data",  host_read_data, 32'h55);
        check_value("hw_bank3", ro_data[3], 32'h55);
        check_value("lw_bank0", ro_data[0], 32'h66);
        tick();
        check_value("hr_hold", host_read_data, 32'h55);
        reset = 1'b1;
        #1 check_value("hr_rst_ack",  32'(host_read_ack), 32'h0);
        check_value("hr_rst_data", host_read_data, 32'h0);
        tick();
        reset = 1'b0; host_read_req = 1'b0;
        repeat (2) tick();
        check_value("end_quiet", 32'(quiescent), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
